// File: rtl/hbm_port_arbiter.sv
// hbm_port_arbiter
//   Shares one HBM controller port among NUM_PORTS requesters. A round-robin
//   arbiter picks one request while the controller is ready, the request is
//   held on the controller enables until the controller drops mem_ready
//   (acceptance), then the block waits for mem_ready to return (completion)
//   and sends a one-cycle response to the owning port. A watchdog forces an
//   error response if ISSUE+BUSY lasts TIMEOUT cycles.
//
// Handshake semantics: a requester raises req_valid[i] with stable
//   req_wr/req_addr/req_wdata and keeps them until it sees req_ready[i]
//   (a one-cycle pulse); the fields are latched on the grant so they may
//   change afterwards. resp_valid[i] is a one-cycle pulse carrying
//   resp_rdata/resp_error and needs no acknowledgement.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid/req_wr        per-port request and direction (1 = write)
//   req_addr/req_wdata      per-port fields, port i at [i*W +: W]
//   req_ready               grant pulse to the winning port
//   resp_valid              completion pulse to the owning port
//   resp_rdata/resp_error   response payload (rdata 0 for writes/errors)
//   mem_*                   controller side (addr, data_in, wr_en, rd_en,
//                           data_out, hbm_ready, hbm_error)
//   timeout_seen            sticky watchdog flag, cleared only by reset
//   state_dbg               current FSM state (0 IDLE,1 ISSUE,2 BUSY,3 RESP)
module hbm_port_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 512,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_wr,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [NUM_PORTS-1:0]        resp_valid,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        resp_error,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_wr_en,
  output logic                        mem_rd_en,
  input  logic [DATA_W-1:0]           mem_rd_data,
  input  logic                        mem_ready,
  input  logic                        mem_error,
  output logic                        timeout_seen,
  output logic [1:0]                  state_dbg
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               state, state_d;
  logic [PW-1:0]        rr_ptr, rr_ptr_d;
  logic [PW-1:0]        owner, owner_d;
  logic                 wr_lat, wr_lat_d;
  logic                 err_lat, err_lat_d;
  logic [TW-1:0]        timer, timer_d;
  logic [NUM_PORTS-1:0] req_ready_d, resp_valid_d;
  logic [DATA_W-1:0]    resp_rdata_d, mem_wdata_d;
  logic [ADDR_W-1:0]    mem_addr_d;
  logic                 resp_error_d, mem_wr_en_d, mem_rd_en_d, timeout_seen_d;

  // Arbitration result
  logic                 grant_found;
  logic [PW-1:0]        grant_idx;
  logic [PW-1:0]        cand;
  logic                 grant_wr;
  logic [ADDR_W-1:0]    grant_addr;
  logic [DATA_W-1:0]    grant_wdata;

  assign state_dbg = state;

  function automatic logic [NUM_PORTS-1:0] port_sel(input logic [PW-1:0] idx);
    port_sel      = '0;
    port_sel[idx] = 1'b1;
  endfunction

  // Round-robin search: first asserted req_valid at or above rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    grant_wr    = 1'b0;
    grant_addr  = '0;
    grant_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NUM_PORTS);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (grant_idx == PW'(j)) begin
        grant_wr    = req_wr[j];
        grant_addr  = req_addr[j*ADDR_W +: ADDR_W];
        grant_wdata = req_wdata[j*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and next-output logic. Every output is a register, so the
  // values computed here appear one cycle later.
  always_comb begin
    state_d        = state;
    rr_ptr_d       = rr_ptr;
    owner_d        = owner;
    wr_lat_d       = wr_lat;
    err_lat_d      = err_lat;
    timer_d        = timer;
    req_ready_d    = '0;
    resp_valid_d   = '0;
    resp_rdata_d   = resp_rdata;
    resp_error_d   = resp_error;
    mem_addr_d     = mem_addr;
    mem_wdata_d    = mem_wdata;
    mem_wr_en_d    = mem_wr_en;
    mem_rd_en_d    = mem_rd_en;
    timeout_seen_d = timeout_seen;

    case (state)
      S_IDLE: begin
        if (mem_ready && grant_found) begin
          owner_d     = grant_idx;
          wr_lat_d    = grant_wr;
          mem_addr_d  = grant_addr;
          mem_wdata_d = grant_wdata;
          req_ready_d = port_sel(grant_idx);
          timer_d     = '0;
          err_lat_d   = 1'b0;
          mem_wr_en_d = grant_wr;
          mem_rd_en_d = !grant_wr;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE, S_BUSY: begin
        // The watchdog is checked before mem_ready so that a timeout wins a
        // same-cycle completion.
        if (timer == TW'(TIMEOUT)) begin
          mem_wr_en_d    = 1'b0;
          mem_rd_en_d    = 1'b0;
          resp_valid_d   = port_sel(owner);
          resp_rdata_d   = '0;
          resp_error_d   = 1'b1;
          timeout_seen_d = 1'b1;
          state_d        = S_RESP;
        end else begin
          timer_d = timer + 1'b1;
          if (state == S_ISSUE) begin
            // mem_ready falling is the controller's acceptance.
            if (!mem_ready) begin
              mem_wr_en_d = 1'b0;
              mem_rd_en_d = 1'b0;
              state_d     = S_BUSY;
            end
          end else begin
            err_lat_d = err_lat | mem_error;
            if (mem_ready) begin
              resp_valid_d = port_sel(owner);
              resp_error_d = err_lat | mem_error;
              resp_rdata_d = (wr_lat || err_lat || mem_error) ? '0 : mem_rd_data;
              state_d      = S_RESP;
            end
          end
        end
      end

      S_RESP: begin
        rr_ptr_d = (owner == PW'(NUM_PORTS - 1)) ? '0 : owner + 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      wr_lat       <= 1'b0;
      err_lat      <= 1'b0;
      timer        <= '0;
      req_ready    <= '0;
      resp_valid   <= '0;
      resp_rdata   <= '0;
      resp_error   <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wr_en    <= 1'b0;
      mem_rd_en    <= 1'b0;
      timeout_seen <= 1'b0;
    end else begin
      state        <= state_d;
      rr_ptr       <= rr_ptr_d;
      owner        <= owner_d;
      wr_lat       <= wr_lat_d;
      err_lat      <= err_lat_d;
      timer        <= timer_d;
      req_ready    <= req_ready_d;
      resp_valid   <= resp_valid_d;
      resp_rdata   <= resp_rdata_d;
      resp_error   <= resp_error_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      mem_wr_en    <= mem_wr_en_d;
      mem_rd_en    <= mem_rd_en_d;
      timeout_seen <= timeout_seen_d;
    end
  end

endmodule

// File: tb/tb_hbm_port_arbiter.sv
// Testbench for hbm_port_arbiter (4 ports, 32-bit address, 512-bit data,
// watchdog of 8 cycles). Directed transactions push their expected grant and
// response records into queues; a monitor pops and compares whenever the DUT
// pulses req_ready or resp_valid. A behavioural controller model answers the
// enables with a configurable accept delay, busy length and error pulse.
module tb_hbm_port_arbiter;

  localparam int NP      = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 512;
  localparam int TIMEOUT = 8;
  localparam int GW      = 3 + 1 + ADDR_W + DATA_W; // {port, wr, addr, wdata}
  localparam int RW      = 3 + 1 + 8 + DATA_W;      // {port, err, latency, rdata}

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [NP-1:0]            req_valid;
  logic [NP-1:0]            req_wr;
  logic [NP*ADDR_W-1:0]     req_addr;
  logic [NP*DATA_W-1:0]     req_wdata;
  logic [NP-1:0]            req_ready;
  logic [NP-1:0]            resp_valid;
  logic [DATA_W-1:0]        resp_rdata;
  logic                     resp_error;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_wr_en;
  logic                     mem_rd_en;
  logic [DATA_W-1:0]        mem_rd_data;
  logic                     mem_ready;
  logic                     mem_error;
  logic                     timeout_seen;
  logic [1:0]               state_dbg;

  // Scoreboard
  logic [GW-1:0] exp_grant_q[$];
  logic [RW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // Shared timing bookkeeping
  int cyc = 0;
  int req_cyc = 0;
  int grant_cyc = 0;
  int resp_count = 0;

  // Requester bookkeeping: valid while issued != granted
  int issued[NP]  = '{default: 0};
  int granted[NP] = '{default: 0};

  // Controller model configuration
  int                drop_dly = 1;
  int                busy_len = 2;
  int                err_at   = -1;
  logic              hang     = 1'b0;
  logic [DATA_W-1:0] rd_data  = '0;

  hbm_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_ready(mem_ready), .mem_error(mem_error), .timeout_seen(timeout_seen),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "simulation time limit");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NP-1:0] port_bit(input logic [2:0] p);
    port_bit = 4'd1 << p;
  endfunction

  task automatic set_req(input int p, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata);
    req_wr[p]                     = wr;
    req_addr[p*ADDR_W +: ADDR_W]  = addr;
    req_wdata[p*DATA_W +: DATA_W] = wdata;
    issued[p]++;
  endtask

  task automatic push_grant(input int p, input logic wr, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata);
    exp_grant_q.push_back({3'(p), wr, addr, wdata});
  endtask

  task automatic push_resp(input int p, input logic err, input logic [7:0] lat,
                           input logic [DATA_W-1:0] rdata);
    exp_q.push_back({3'(p), err, lat, rdata});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    req_cyc = cyc;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_grant_q.size() == 0 && exp_q.size() == 0 && state_dbg == 2'd0 && mem_ready) begin
        done = 1'b1;
        break;
      end
    end
    check(name, done, 1'b1);
  endtask

  // ---------------- requester driver ----------------
  initial begin
    req_valid = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) if (req_ready[i]) granted[i]++;
      @(posedge clk);
      #2;
      for (int i = 0; i < NP; i++) req_valid[i] = (issued[i] != granted[i]);
    end
  end

  // ---------------- controller model ----------------
  initial begin
    mem_ready   = 1'b1;
    mem_error   = 1'b0;
    mem_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if ((mem_rd_en || mem_wr_en) && !hang) begin
        for (int k = 0; k < drop_dly; k++) begin @(posedge clk); #1; end
        mem_ready   = 1'b0;
        mem_rd_data = {16{32'hDEADBEEF}};
        mem_error   = (err_at == 0);
        for (int k = 1; k < busy_len; k++) begin
          @(posedge clk);
          #1;
          mem_error = (err_at == k);
        end
        @(posedge clk);
        #1;
        mem_error   = 1'b0;
        mem_ready   = 1'b1;
        mem_rd_data = rd_data;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [GW-1:0] mg;
  logic [RW-1:0] mr;
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (req_ready != '0) begin
          grant_cyc = cyc;
          if (exp_grant_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: req_ready=%0h with no grant expected", req_ready);
          end else begin
            mg = exp_grant_q.pop_front();
            check("grant_port", req_ready, port_bit(mg[GW-1 -: 3]));
            check("grant_wr_en", mem_wr_en, mg[GW-4]);
            check("grant_rd_en", mem_rd_en, !mg[GW-4]);
            check("grant_addr", mem_addr, mg[DATA_W +: ADDR_W]);
            check("grant_wdata", mem_wdata, mg[DATA_W-1:0]);
          end
        end
        if (resp_valid != '0) begin
          resp_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: resp_valid=%0h with no response expected", resp_valid);
          end else begin
            mr = exp_q.pop_front();
            check("resp_port", resp_valid, port_bit(mr[RW-1 -: 3]));
            check("resp_error", resp_error, mr[RW-4]);
            check("resp_rdata", resp_rdata, mr[DATA_W-1:0]);
            check("resp_enables_off", {mem_wr_en, mem_rd_en}, 2'b00);
            if (mr[DATA_W +: 8] != 8'hFF)
              check("resp_latency", cyc - grant_cyc, mr[DATA_W +: 8]);
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int n_en;
  int seen;
  int resp_before;
  initial begin
    reset_n   = 1'b0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    #1;
    check("rst_req_ready", req_ready, '0);
    check("rst_resp_valid", resp_valid, '0);
    check("rst_resp", {resp_error, resp_rdata}, '0);
    check("rst_mem_en", {mem_wr_en, mem_rd_en}, 2'b00);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_timeout_seen", timeout_seen, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Round-robin: all ports request, port 0 twice; order 0,1,2,3,0.
    drop_dly = 1; busy_len = 2; err_at = -1;
    rd_data  = {16{32'h0BADF00D}};
    push_grant(0, 1'b0, 32'h1000, '0);
    push_grant(1, 1'b0, 32'h1010, '0);
    push_grant(2, 1'b0, 32'h1020, '0);
    push_grant(3, 1'b0, 32'h1030, '0);
    push_grant(0, 1'b0, 32'h1000, '0);
    for (int p = 0; p < NP; p++) push_resp(p, 1'b0, 8'd4, {16{32'h0BADF00D}});
    push_resp(0, 1'b0, 8'd4, {16{32'h0BADF00D}});
    tick();
    set_req(0, 1'b0, 32'h1000, '0);
    set_req(0, 1'b0, 32'h1000, '0);
    set_req(1, 1'b0, 32'h1010, '0);
    set_req(2, 1'b0, 32'h1020, '0);
    set_req(3, 1'b0, 32'h1030, '0);
    wait_done("rr_done", 200);

    // Single read on port 2: accept after 1 cycle, 6 busy cycles.
    drop_dly = 1; busy_len = 6;
    rd_data  = {64{8'hA5}};
    push_grant(2, 1'b0, 32'h100, '0);
    push_resp(2, 1'b0, 8'd8, {64{8'hA5}});
    tick();
    set_req(2, 1'b0, 32'h100, '0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[2]) begin seen = 1; break; end
    end
    check("read_grant_seen", seen, 1);
    check("read_grant_latency", cyc - req_cyc, 1);
    n_en = 0;
    while (mem_rd_en && n_en < 20) begin
      n_en++;
      @(negedge clk);
    end
    check("read_rd_en_cycles", n_en, 2);
    wait_done("read_done", 100);

    // Write on port 1: fields pass through, rdata returns 0.
    busy_len = 3;
    push_grant(1, 1'b1, 32'h2000, {64{8'h55}});
    push_resp(1, 1'b0, 8'd5, '0);
    tick();
    set_req(1, 1'b1, 32'h2000, {64{8'h55}});
    wait_done("write_done", 100);

    // Controller error during BUSY on port 3, then a clean read on port 0.
    busy_len = 4; err_at = 1;
    push_grant(3, 1'b0, 32'h300, '0);
    push_resp(3, 1'b1, 8'd6, '0);
    tick();
    set_req(3, 1'b0, 32'h300, '0);
    wait_done("err_done", 100);
    err_at  = -1;
    rd_data = {16{32'h12345678}};
    push_grant(0, 1'b0, 32'h400, '0);
    push_resp(0, 1'b0, 8'd6, {16{32'h12345678}});
    tick();
    set_req(0, 1'b0, 32'h400, '0);
    wait_done("clean_done", 100);
    check("timeout_seen_before", timeout_seen, 1'b0);

    // Timeout: controller never drops ready; response TIMEOUT+1 after grant.
    hang = 1'b1;
    push_grant(0, 1'b0, 32'h500, '0);
    push_resp(0, 1'b1, 8'(TIMEOUT + 1), '0);
    tick();
    set_req(0, 1'b0, 32'h500, '0);
    wait_done("timeout_done", 100);
    check("timeout_seen_after", timeout_seen, 1'b1);
    hang = 1'b0;

    // Reset while BUSY on port 3: no response, outputs cleared at once.
    busy_len = 6;
    push_grant(3, 1'b0, 32'h600, '0);
    tick();
    set_req(3, 1'b0, 32'h600, '0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (state_dbg == 2'd2) begin seen = 1; break; end
    end
    check("abort_reached_busy", seen, 1);
    resp_before = resp_count;
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_req_ready", req_ready, '0);
    check("abort_resp_valid", resp_valid, '0);
    check("abort_mem_en", {mem_wr_en, mem_rd_en}, 2'b00);
    check("abort_mem_addr", mem_addr, '0);
    check("abort_timeout_seen", timeout_seen, 1'b0);
    check("abort_state", state_dbg, 2'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (mem_ready) begin seen = 1; break; end
    end
    check("abort_ctrl_idle", seen, 1);
    check("abort_no_resp", resp_count, resp_before);

    // After reset, port 0 wins over port 2 even though the old pointer was 1.
    busy_len = 2;
    rd_data  = {16{32'hCAFE0001}};
    push_grant(0, 1'b0, 32'h700, '0);
    push_grant(2, 1'b0, 32'h720, '0);
    push_resp(0, 1'b0, 8'd4, {16{32'hCAFE0001}});
    push_resp(2, 1'b0, 8'd4, {16{32'hCAFE0001}});
    tick();
    set_req(0, 1'b0, 32'h700, '0);
    set_req(2, 1'b0, 32'h720, '0);
    wait_done("post_reset_done", 100);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
